// File: rtl/tl_pkg.sv
// TileLink-UL shared definitions: field widths, opcode constants and the
// response payload carried by the responder's one-entry D register.
package tl_pkg;

  localparam int unsigned OPCODE_W = 3;
  localparam int unsigned PARAM_W  = 2;
  localparam int unsigned SIZE_W   = 4;
  localparam int unsigned SINK_W   = 3;
  localparam int unsigned ADDR_W   = 32;
  localparam int unsigned DATA_W   = 64;
  localparam int unsigned MASK_W   = 8;

  localparam logic [OPCODE_W-1:0] TL_PUT_FULL_DATA    = 3'd0;
  localparam logic [OPCODE_W-1:0] TL_PUT_PARTIAL_DATA = 3'd1;
  localparam logic [OPCODE_W-1:0] TL_GET              = 3'd4;
  localparam logic [OPCODE_W-1:0] TL_ACCESS_ACK       = 3'd0;
  localparam logic [OPCODE_W-1:0] TL_ACCESS_ACK_DATA  = 3'd1;

  typedef enum logic {
    RSP_EMPTY = 1'b0,
    RSP_FULL  = 1'b1
  } rsp_state_e;

  typedef struct packed {
    logic [OPCODE_W-1:0] opcode;
    logic [SIZE_W-1:0]   size;
    logic                denied;
    logic                corrupt;
    logic                has_data;
  } d_rsp_t;

  // Low address bits that must be zero for a transfer of 2^size bytes.
  function automatic logic [2:0] align_mask(input logic [1:0] size);
    return 3'((4'd1 << size) - 4'd1);
  endfunction

endpackage

// File: rtl/tl_ram_sp.sv
// Single-port 64-bit RAM with per-byte write mask and registered read data.
module tl_ram_sp
  import tl_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 512,
  parameter int unsigned IDX_W       = $clog2(DEPTH_WORDS)
) (
  input  logic              clk,
  input  logic              en_i,
  input  logic              we_i,
  input  logic [IDX_W-1:0]  addr_i,
  input  logic [MASK_W-1:0] wmask_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH_WORDS];
  logic [DATA_W-1:0] rdata_q;

  // Read data only updates on a read, so it holds while a response stalls.
  always_ff @(posedge clk) begin
    if (en_i) begin
      if (we_i) begin
        for (int b = 0; b < MASK_W; b++) begin
          if (wmask_i[b]) begin
            mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
          end
        end
      end else begin
        rdata_q <= mem_q[addr_i];
      end
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/tl_ram_responder.sv
// TL-UL manager fronting a byte-masked RAM window: legality decode plus a
// one-entry response register that sustains one beat per cycle.
module tl_ram_responder
  import tl_pkg::*;
#(
  parameter logic [ADDR_W-1:0] BASE_ADDR   = 32'h8000_0000,
  parameter int unsigned       DEPTH_WORDS = 512
) (
  input  logic                clock,
  input  logic                reset,
  output logic                auto_in_a_ready,
  input  logic                auto_in_a_valid,
  input  logic [OPCODE_W-1:0] auto_in_a_bits_opcode,
  input  logic [SIZE_W-1:0]   auto_in_a_bits_size,
  input  logic [ADDR_W-1:0]   auto_in_a_bits_address,
  input  logic [MASK_W-1:0]   auto_in_a_bits_mask,
  input  logic [DATA_W-1:0]   auto_in_a_bits_data,
  input  logic                auto_in_d_ready,
  output logic                auto_in_d_valid,
  output logic [OPCODE_W-1:0] auto_in_d_bits_opcode,
  output logic [PARAM_W-1:0]  auto_in_d_bits_param,
  output logic [SIZE_W-1:0]   auto_in_d_bits_size,
  output logic [SINK_W-1:0]   auto_in_d_bits_sink,
  output logic                auto_in_d_bits_denied,
  output logic [DATA_W-1:0]   auto_in_d_bits_data,
  output logic                auto_in_d_bits_corrupt
);

  localparam int unsigned       IDX_W        = $clog2(DEPTH_WORDS);
  localparam logic [ADDR_W-1:0] WINDOW_BYTES = ADDR_W'(DEPTH_WORDS * 8);

  rsp_state_e        state_q, state_d;
  d_rsp_t            rsp_q, rsp_d;
  logic              a_fire, d_fire;
  logic [ADDR_W-1:0] offset;
  logic              is_get, is_put, op_ok, size_ok, range_ok, align_ok, legal;
  logic [DATA_W-1:0] ram_rdata;

  assign auto_in_a_ready = (state_q == RSP_EMPTY) || auto_in_d_ready;
  assign a_fire          = auto_in_a_valid && auto_in_a_ready;
  assign d_fire          = (state_q == RSP_FULL) && auto_in_d_ready;

  // Addresses below BASE_ADDR wrap to a large offset and fail the range test.
  assign offset   = auto_in_a_bits_address - BASE_ADDR;
  assign is_get   = auto_in_a_bits_opcode == TL_GET;
  assign is_put   = (auto_in_a_bits_opcode == TL_PUT_FULL_DATA) ||
                    (auto_in_a_bits_opcode == TL_PUT_PARTIAL_DATA);
  assign op_ok    = is_get || is_put;
  assign size_ok  = auto_in_a_bits_size <= SIZE_W'(3);
  assign range_ok = offset < WINDOW_BYTES;
  assign align_ok = (auto_in_a_bits_address[2:0] & align_mask(auto_in_a_bits_size[1:0])) == 3'b000;
  assign legal    = op_ok && size_ok && range_ok && align_ok;

  tl_ram_sp #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .IDX_W       (IDX_W)
  ) u_ram (
    .clk     (clock),
    .en_i    (a_fire && legal),
    .we_i    (is_put),
    .addr_i  (offset[IDX_W+2:3]),
    .wmask_i (auto_in_a_bits_mask),
    .wdata_i (auto_in_a_bits_data),
    .rdata_o (ram_rdata)
  );

  // Response FSM: a new beat always overwrites the slot, including on D fire.
  always_comb begin
    state_d = state_q;
    rsp_d   = rsp_q;
    case (state_q)
      RSP_EMPTY: if (a_fire) state_d = RSP_FULL;
      RSP_FULL:  if (d_fire && !a_fire) state_d = RSP_EMPTY;
      default:   state_d = RSP_EMPTY;
    endcase
    if (a_fire) begin
      rsp_d.opcode   = is_get ? TL_ACCESS_ACK_DATA : TL_ACCESS_ACK;
      rsp_d.size     = auto_in_a_bits_size;
      rsp_d.denied   = !legal;
      rsp_d.corrupt  = !legal && is_get;
      rsp_d.has_data = legal && is_get;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= RSP_EMPTY;
      rsp_q   <= '0;
    end else begin
      state_q <= state_d;
      rsp_q   <= rsp_d;
    end
  end

  assign auto_in_d_valid        = state_q == RSP_FULL;
  assign auto_in_d_bits_opcode  = rsp_q.opcode;
  assign auto_in_d_bits_param   = '0;
  assign auto_in_d_bits_size    = rsp_q.size;
  assign auto_in_d_bits_sink    = '0;
  assign auto_in_d_bits_denied  = rsp_q.denied;
  assign auto_in_d_bits_corrupt = rsp_q.corrupt;
  assign auto_in_d_bits_data    = rsp_q.has_data ? ram_rdata : '0;

endmodule
